// File: rtl/sha256_w_schedule.sv
// ---------------------------------------------------------------------------
// sha256_w_schedule
//
// Message-schedule stage for the SHA-256 core. A 512-bit block arrives as
// sixteen 32-bit words over a valid/ready handshake. The stage then streams
// the expanded schedule words W[0..NUM_ROUNDS-1], one per clock, to the
// round datapath. The round datapath cannot stall this stream.
//
// Ports:
//   clk       core clock
//   rst_n     synchronous active-low reset
//   clear     synchronous abort; drops any partial load or run, back to LOAD
//   in_valid  in_data holds a valid message word
//   in_ready  stage accepts a word this cycle (high throughout LOAD)
//   in_data   message word, big-endian, M0 first
//   w_valid   w_data is valid this cycle (high throughout RUN)
//   w_data    schedule word W[w_round]
//   w_round   index t of the current w_data
//   w_first   marks t == 0; initialises the downstream round counter
//   w_last    marks t == NUM_ROUNDS-1
// ---------------------------------------------------------------------------
module sha256_w_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        w_valid,
    output logic [31:0] w_data,
    output logic [5:0]  w_round,
    output logic        w_first,
    output logic        w_last
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_next;

    // Small sigma functions of the schedule recurrence. The rotates are
    // written as bit concatenations, so they are pure wiring.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Next schedule word. The window holds W[t..t+15], so the word needed at
    // t+16 uses offsets 14, 9, 1 and 0. The adders wrap mod 2^32.
    always_comb begin
        w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    end

    // Next-state logic. clear overrides everything except reset, including a
    // word offered in the same cycle. In LOAD the window fills from the top.
    // In RUN the same shift-and-append rule runs every cycle, so the sixteen
    // message words drain out unmodified as W[0..15] before any computed
    // word reaches win[0].
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        round_d = round_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        if (clear) begin
            state_d = LOAD;
            count_d = '0;
            round_d = '0;
            for (int i = 0; i < 16; i++) begin
                win_d[i] = '0;
            end
        end else if (state_q == LOAD) begin
            if (in_valid) begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[15] = in_data;
                if (count_q == 4'd15) begin
                    state_d = RUN;
                    count_d = '0;
                    round_d = '0;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
            if (round_q == LAST_ROUND) begin
                state_d = LOAD;
                round_d = '0;
            end else begin
                round_d = round_q + 6'd1;
            end
        end
    end

    // State registers. Reset is synchronous, and the window is zeroed so
    // w_data reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            count_q <= '0;
            round_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            round_q <= round_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Outputs are decoded from registers only, so no combinational path runs
    // from in_* to w_*. w_data is forced to zero outside RUN so that words
    // sitting in a partially loaded window never leak out.
    always_comb begin
        in_ready = (state_q == LOAD);
        w_valid  = (state_q == RUN);
        w_data   = (state_q == RUN) ? win_q[0] : 32'h0;
        w_round  = round_q;
        w_first  = (state_q == RUN) && (round_q == 6'd0);
        w_last   = (state_q == RUN) && (round_q == LAST_ROUND);
    end

endmodule

// File: tb/tb_sha256_w_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_w_schedule
//
// Scoreboard bench for sha256_w_schedule. Before each block is loaded, the
// driver pushes that block's expected W stream. Each entry holds the data,
// the round index and the first/last flags. Where hand-computed values are
// known, they replace the reference-model values in the pushed entries. A
// monitor pops and compares one entry for every cycle that w_valid is high.
// ---------------------------------------------------------------------------
module tb_sha256_w_schedule;

    localparam int NR = 64;

    typedef logic [31:0] block_t [16];

    typedef struct {
        logic [31:0] data;
        logic [5:0]  round;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic [31:0] w_data;
    logic [5:0]  w_round;
    logic        w_first;
    logic        w_last;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          prev_first_cyc = -1;
    int          first_gap = 0;
    int          run_len = 0;
    int          last_len = 0;
    exp_t        sbq[$];
    logic [31:0] model_w [64];
    block_t      abc_blk;
    block_t      ones_blk;

    sha256_w_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_valid  (w_valid),
        .w_data   (w_data),
        .w_round  (w_round),
        .w_first  (w_first),
        .w_last   (w_last)
    );

    // Free-running clock and a cycle counter used for the latency and
    // period measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point. Every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model written as the textbook recurrence over a flat array,
    // independent of the sliding-window structure in the design.
    function automatic logic [31:0] ss0(input logic [31:0] x);
        ss0 = ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        ss1 = ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic expand_model(input block_t m);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) model_w[t] = m[t];
            else model_w[t] = ss1(model_w[t-2]) + model_w[t-7] + ss0(model_w[t-15]) + model_w[t-16];
        end
    endtask

    // Push the first n expected words of a block. hand selects a set of
    // hand-computed values that override the model: 1 = "abc" block,
    // 2 = all-ones block. For the all-ones block the rotations cancel
    // (x ^ x), so s0 reduces to SHR3 = 0x1FFFFFFF and s1 to
    // SHR10 = 0x003FFFFF. W16 is then -2 + 0x1FFFFFFF + 0x003FFFFF,
    // which is 0x203FFFFC.
    task automatic push_expected(input block_t m, input int n, input int hand);
        exp_t e;
        expand_model(m);
        if (hand == 1) begin
            model_w[0]  = 32'h61626380;
            model_w[15] = 32'h00000018;
            model_w[16] = 32'h61626380;
            model_w[17] = 32'h000F0000;
            model_w[63] = 32'h12B1EDEB;
        end else if (hand == 2) begin
            model_w[16] = 32'h203FFFFC;
        end
        for (int t = 0; t < n; t++) begin
            e.data  = model_w[t];
            e.round = 6'(t);
            e.first = (t == 0);
            e.last  = (t == NR - 1);
            sbq.push_back(e);
        end
    endtask

    // Monitor: on every cycle with w_valid it pops one expected entry and
    // compares all four fields. It also records the spacing of w_first and
    // the length of each run.
    always @(negedge clk) begin
        exp_t e;
        if (w_valid === 1'b1) begin
            if (w_first === 1'b1) begin
                if (prev_first_cyc >= 0) first_gap = cyc - prev_first_cyc;
                prev_first_cyc = cyc;
                run_len = 1;
            end else begin
                run_len++;
            end
            if (w_last === 1'b1) last_len = run_len;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: w_valid with round %0d data 0x%08h but nothing expected", w_round, w_data);
            end else begin
                e = sbq.pop_front();
                checkOutput($sformatf("w_data[t=%0d]", e.round), w_data, e.data);
                checkOutput($sformatf("w_round[t=%0d]", e.round), 32'(w_round), 32'(e.round));
                checkOutput($sformatf("w_first[t=%0d]", e.round), 32'(w_first), 32'(e.first));
                checkOutput($sformatf("w_last[t=%0d]", e.round), 32'(w_last), 32'(e.last));
            end
        end
    end

    // Check that every output holds its reset value.
    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        checkOutput({tag, "_w_first"}, 32'(w_first), 32'd0);
        checkOutput({tag, "_w_last"}, 32'(w_last), 32'd0);
        checkOutput({tag, "_w_round"}, 32'(w_round), 32'd0);
        checkOutput({tag, "_w_data"}, w_data, 32'd0);
    endtask

    // Drive the first n words of a block. Call it at posedge+1. With
    // throttle set, an idle cycle goes between words. With a full block it
    // returns at the negedge of the W0 cycle, after checking that W0
    // appeared exactly one cycle after the last handshake.
    task automatic applyStimulus(input block_t m, input int n, input bit throttle, input bit hold_valid);
        for (int i = 0; i < n; i++) begin
            if (throttle && i > 0) begin
                in_valid = 1'b0;
                in_data  = 32'h0BAD0BAD;
                @(negedge clk);
                checkOutput("in_ready_gap", 32'(in_ready), 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = m[i];
            @(negedge clk);
            checkOutput("in_ready_load", 32'(in_ready), 32'd1);
            checkOutput("w_valid_load", 32'(w_valid), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = hold_valid;
        in_data  = 32'hDEADBEEF;
        if (n == 16) begin
            @(negedge clk);
            checkOutput("w0_latency_valid", 32'(w_valid), 32'd1);
            checkOutput("w0_latency_first", 32'(w_first), 32'd1);
        end
    endtask

    // Step from the W0 negedge through W[NR-1]. Optionally check that
    // in_ready stays low for every RUN cycle. Returns at posedge+1 of the
    // first LOAD cycle.
    task automatic run_to_last(input bit check_ready);
        if (check_ready) checkOutput("in_ready_run", 32'(in_ready), 32'd0);
        for (int k = 1; k < NR; k++) begin
            @(negedge clk);
            if (check_ready) checkOutput("in_ready_run", 32'(in_ready), 32'd0);
        end
        checkOutput("w_last_final", 32'(w_last), 32'd1);
        @(posedge clk); #1;
    endtask

    // Bound on total run time. Reaching it means something hung.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time bound, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    // Main directed sequence.
    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 16; i++) begin
            abc_blk[i]  = 32'h0;
            ones_blk[i] = 32'hFFFFFFFF;
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        $display("[TB] abc block");
        @(posedge clk); #1;
        push_expected(abc_blk, 64, 1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b0);
        run_to_last(1'b0);
        checkOutput("run_length", 32'(last_len), 32'd64);

        $display("[TB] throttled abc block");
        push_expected(abc_blk, 64, 1);
        applyStimulus(abc_blk, 16, 1'b1, 1'b0);
        run_to_last(1'b0);

        $display("[TB] back-to-back abc blocks");
        push_expected(abc_blk, 64, 1);
        push_expected(abc_blk, 64, 1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b1);
        run_to_last(1'b1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b1);
        run_to_last(1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_period", 32'(first_gap), 32'd80);

        $display("[TB] clear at t=20");
        @(posedge clk); #1;
        push_expected(abc_blk, 21, 1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b0);
        for (int k = 1; k < 20; k++) @(negedge clk);
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_w_valid", 32'(w_valid), 32'd0);
        checkOutput("clear_w_last", 32'(w_last), 32'd0);
        checkOutput("clear_in_ready", 32'(in_ready), 32'd1);
        checkOutput("clear_w_round", 32'(w_round), 32'd0);
        @(posedge clk); #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        push_expected(abc_blk, 64, 1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b0);
        run_to_last(1'b0);

        $display("[TB] reset after partial load");
        applyStimulus(abc_blk, 7, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("partial_hold_w_valid", 32'(w_valid), 32'd0);
            checkOutput("partial_hold_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");
        @(posedge clk); #1;
        push_expected(abc_blk, 64, 1);
        applyStimulus(abc_blk, 16, 1'b0, 1'b0);
        run_to_last(1'b0);

        $display("[TB] all-ones block");
        push_expected(ones_blk, 64, 2);
        applyStimulus(ones_blk, 16, 1'b0, 1'b0);
        run_to_last(1'b0);

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
